// File: rtl/sys_cfg_regs_pkg.sv
// sys_cfg_pkg: shared state encoding, default command base and pointer sizing for sys_cfg_regs.
package sys_cfg_pkg;
    typedef enum logic [2:0] {IDLE, CMD, DATA, FULL, SKIP} state_t;
    localparam logic [7:0] CMD_BASE_DEF = 8'h01;
    function automatic int ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/sys_cfg_regs_if.sv
// sys_cfg_regs_if: HPS UIO word channel (transaction level, strobe, data in, readback out).
interface sys_cfg_regs_if;
    logic        uio;
    logic        strobe;
    logic [15:0] din;
    logic [15:0] dout;
    modport master (output uio, strobe, din, input dout);
    modport slave  (input uio, strobe, din, output dout);
endinterface

// File: rtl/sys_edge_det.sv
// sys_edge_det: 1-bit rising-edge detector with asynchronous active-high reset.
module sys_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic q;
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= 1'b0;
        else     q <= d;
    assign rise = d & ~q;
endmodule

// File: rtl/sys_cfg_regs.sv
// sys_cfg_regs: UIO command range decoder into NUM_REGS shadowed config registers, committed atomically at transaction end.
// Optional readback of the addressed live register on io.dout when SYS_CFG_READBACK_EN is defined.
module sys_cfg_regs
    import sys_cfg_pkg::*;
#(
    parameter int              DW       = 16,
    parameter int              NUM_REGS = 4,
    parameter logic [7:0]      CMD_BASE = CMD_BASE_DEF,
    parameter logic [DW-1:0]   RST_VAL  = '0
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    sys_cfg_regs_if.slave          io,
    output logic [NUM_REGS*DW-1:0] cfg,
    output logic [NUM_REGS-1:0]    cfg_ready,
    output logic [NUM_REGS-1:0]    cfg_upd,
    output logic                   cfg_err
);
    localparam int PW = ptr_w(NUM_REGS);
    localparam logic [PW-1:0] LAST = PW'(NUM_REGS - 1);

    state_t                     state, nxt;
    logic [PW-1:0]              ptr;
    logic [NUM_REGS-1:0][DW-1:0] shadow;
    logic [NUM_REGS-1:0]        dirty;
    logic                       ev, done, wr, ovf, ld, idx_ok;
    logic [7:0]                 idx;

    sys_edge_det u_edge (.clk(clk_sys), .rst(reset), .d(io.strobe), .rise(ev));

    assign idx    = io.din[7:0] - CMD_BASE;
    assign idx_ok = idx < 8'(NUM_REGS);

    always_ff @(posedge clk_sys or posedge reset)
        if (reset) state <= IDLE;
        else       state <= nxt;

    // Dropping io.uio always wins over a strobe event in the same cycle
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = io.uio ? CMD : IDLE;
            CMD:     nxt = !io.uio ? IDLE : ev ? (idx_ok ? DATA : SKIP) : CMD;
            DATA:    nxt = !io.uio ? IDLE : (ev && ptr == LAST) ? FULL : DATA;
            default: nxt = io.uio ? state : IDLE;
        endcase
    end

    always_comb begin
        done = state != IDLE && !io.uio;
        wr   = state == DATA && io.uio && ev;
        ovf  = state == FULL && io.uio && ev;
        ld   = state == CMD  && io.uio && ev && idx_ok;
    end

    always_ff @(posedge clk_sys or posedge reset)
        if (reset) begin
            ptr       <= '0;
            shadow    <= {NUM_REGS{RST_VAL}};
            cfg       <= {NUM_REGS{RST_VAL}};
            dirty     <= '0;
            cfg_ready <= '0;
            cfg_upd   <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= ovf;
            cfg_upd <= done ? dirty : '0;
            if (ld)                      ptr <= idx[PW-1:0];
            else if (wr && ptr != LAST)  ptr <= ptr + 1'b1;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr && ptr == PW'(k)) begin
                    shadow[k] <= io.din[DW-1:0];
                    dirty[k]  <= 1'b1;
                end
                if (done && dirty[k]) cfg[k*DW +: DW] <= shadow[k];
            end
            if (done) begin
                cfg_ready <= cfg_ready | dirty;
                dirty     <= '0;
            end
        end

`ifdef SYS_CFG_READBACK_EN
    logic [DW-1:0] rb;
    logic [15:0]   dout_q;
    always_comb begin
        rb = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (ptr == PW'(k)) rb = cfg[k*DW +: DW];
    end
    always_ff @(posedge clk_sys or posedge reset)
        if (reset) dout_q <= '0;
        else       dout_q <= state == DATA ? 16'(rb) :
                             (state == FULL || state == SKIP) ? 16'hFFFF : 16'h0000;
    assign io.dout = dout_q;
`else
    assign io.dout = '0;
`endif
endmodule

// File: tb/tb_sys_cfg_regs.sv
// tb_sys_cfg_regs: directed and randomized UIO transactions against a transaction-level register model.
module tb_sys_cfg_regs;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic [63:0] cfg;
    logic [3:0]  cfg_ready, cfg_upd;
    logic        cfg_err;

    sys_cfg_regs_if bus ();

    sys_cfg_regs dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .io       (bus.slave),
        .cfg      (cfg),
        .cfg_ready(cfg_ready),
        .cfg_upd  (cfg_upd),
        .cfg_err  (cfg_err)
    );

    always #5 clk_sys = ~clk_sys;

    int          checks = 0, failures = 0;
    logic [15:0] live [4];
    logic [3:0]  rdy_m;
    int          err_cnt = 0;
    int          upd_cnt [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] live_vec();
        return {live[3], live[2], live[1], live[0]};
    endfunction

    always @(negedge clk_sys)
        if (!reset) begin
            if (cfg_err) err_cnt++;
            for (int k = 0; k < 4; k++) if (cfg_upd[k]) upd_cnt[k]++;
        end

    task automatic send(input logic [15:0] d, input int hold);
        bus.din    = d;
        bus.strobe = 1'b1;
        repeat (hold) @(negedge clk_sys);
        bus.strobe = 1'b0;
        @(negedge clk_sys);
    endtask

    // One UIO transaction: command word, n data words, then io_uio low (optionally with a colliding strobe)
    task automatic txn(input logic [7:0] cmd, input int n, input logic [15:0] w [6],
                       input int hold, input bit late, input string tag);
        int          idx, nerr, e0;
        int          u0 [4];
        logic [3:0]  mask;
        logic [15:0] nxt [4];
        e0 = err_cnt; u0 = upd_cnt; nxt = live; mask = '0; nerr = 0;
        idx = int'(8'(cmd - 8'h01));
        @(negedge clk_sys) bus.uio = 1'b1;
        @(negedge clk_sys);
        send({8'h00, cmd}, hold);
`ifdef SYS_CFG_READBACK_EN
        check({tag, ".dout"}, 64'(bus.dout), idx < 4 ? 64'(live[idx]) : 64'hFFFF);
`else
        check({tag, ".dout"}, 64'(bus.dout), 64'h0);
`endif
        for (int i = 0; i < n; i++) begin
            send(w[i], hold);
            if (idx < 4) begin
                if (idx + i < 4) begin nxt[idx+i] = w[i]; mask[idx+i] = 1'b1; end
                else nerr++;
            end
            check({tag, ".atomic"}, cfg, live_vec());
        end
        bus.uio = 1'b0;
        if (late) begin bus.din = 16'hDEAD; bus.strobe = 1'b1; end
        @(negedge clk_sys);
        bus.strobe = 1'b0;
        live = nxt;
        rdy_m |= mask;
        check({tag, ".cfg"}, cfg, live_vec());
        check({tag, ".upd"}, 64'(cfg_upd), 64'(mask));
        check({tag, ".ready"}, 64'(cfg_ready), 64'(rdy_m));
        @(negedge clk_sys);
        check({tag, ".upd_clr"}, 64'(cfg_upd), 64'h0);
        @(negedge clk_sys);
        check({tag, ".err"}, 64'(err_cnt - e0), 64'(nerr));
        for (int k = 0; k < 4; k++) check({tag, ".upd_cnt"}, 64'(upd_cnt[k] - u0[k]), 64'(mask[k]));
    endtask

    initial begin
        logic [15:0] w [6];
        int          u0 [4];
        for (int k = 0; k < 4; k++) begin live[k] = '0; upd_cnt[k] = 0; end
        rdy_m = '0;
        bus.uio = 1'b0; bus.strobe = 1'b0; bus.din = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("rst.cfg", cfg, 64'h0);
        check("rst.ready", 64'(cfg_ready), 64'h0);
        check("rst.upd", 64'(cfg_upd), 64'h0);
        check("rst.err", 64'(cfg_err), 64'h0);
        check("rst.dout", 64'(bus.dout), 64'h0);
        reset = 1'b0;
        @(negedge clk_sys);

        w = '{16'h1234, 0, 0, 0, 0, 0};
        txn(8'h01, 1, w, 1, 1'b0, "single");
        w = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 0, 0, 0};
        txn(8'h02, 3, w, 1, 1'b0, "autoinc");
        w = '{16'h1111, 16'h2222, 0, 0, 0, 0};
        txn(8'h04, 2, w, 1, 1'b0, "overflow");
        w = '{16'h5A5A, 16'hA5A5, 0, 0, 0, 0};
        txn(8'h05, 2, w, 1, 1'b0, "foreign05");
        txn(8'h00, 2, w, 1, 1'b0, "foreign00");
        txn(8'h03, 0, w, 1, 1'b0, "empty");
        w = '{16'h5555, 0, 0, 0, 0, 0};
        txn(8'h01, 1, w, 5, 1'b0, "hold5");
        w = '{16'h7777, 0, 0, 0, 0, 0};
        txn(8'h03, 1, w, 1, 1'b1, "late");
        txn(8'h01, 3, w, 2, 1'b0, "readback");

        // Reset in the middle of DATA after one word
        u0 = upd_cnt;
        @(negedge clk_sys) bus.uio = 1'b1;
        @(negedge clk_sys);
        send(16'h0001, 1);
        send(16'h9999, 1);
        reset = 1'b1;
        @(negedge clk_sys);
        bus.uio = 1'b0;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) live[k] = '0;
        rdy_m = '0;
        repeat (2) @(negedge clk_sys);
        check("midrst.cfg", cfg, 64'h0);
        check("midrst.ready", 64'(cfg_ready), 64'h0);
        check("midrst.upd", 64'(cfg_upd), 64'h0);
        for (int k = 0; k < 4; k++) check("midrst.upd_cnt", 64'(upd_cnt[k] - u0[k]), 64'h0);

        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
            txn(8'($urandom_range(0, 6)), int'($urandom_range(0, 6)), w,
                int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
